keypad_scan_ctrl: RTL and testbench
===================================

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 Parameter DWELL, default 4: cycles each column is driven; legal range 2..255.
REQ-002 Parameter DEB_SCANS, default 3: consecutive identical frames needed to accept a key state; legal range 2..15.
REQ-003 Parameter FIFO_DEPTH, default 4: event queue depth; power of two, at least 2.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_s  in  4  row returns, active-high; bit r = row r.
REQ-007 out_s  out  4  one-hot column drive.
REQ-008 evt_valid  out  1  event queue non-empty.
REQ-009 evt_ready  in  1  consumer accepts the head event.
REQ-010 evt_code  out  5  [3:0] key index 0..15; [4] release flag.
REQ-011 key_down  out  1  at least one key is in the debounced-pressed state.
REQ-012 overflow  out  1  sticky flag: an event was dropped.

Function
REQ-013 The column counter col (0..3) drives out_s as follows: col 0 = 1000, col 1 = 0100, col 2 = 0010, col 3 = 0001.
REQ-014 Each column is held DWELL cycles; in_s is sampled on the last dwell cycle into raw[col*4 + r].
REQ-015 A frame completes when col 3 is sampled; frame period is 4*DWELL cycles (16 at defaults).
REQ-016 At frame end the raw frame is compared with the previous frame.
REQ-017 If the frames are equal, stable_cnt increments, saturating at 15; otherwise stable_cnt is cleared to 0.
REQ-018 When stable_cnt reaches DEB_SCANS-1 and raw differs from deb, the block computes press = raw & ~deb and release = deb & ~raw, loads deb <= raw, and enters EMIT.
REQ-019 FSM states are SCAN and EMIT; EMIT returns to SCAN once no pending bits remain.
REQ-020 In EMIT, out_s = 0000, the column and dwell counters are frozen, and scanning resumes at col 0 with a full dwell.
REQ-021 EMIT pushes one event per cycle in ascending key index.
REQ-022 The push code is {1'b0, key} for a press; releases are governed by REQ-033/034.
REQ-023 key_down = OR of deb, registered.
REQ-024 The event FIFO is show-ahead: evt_valid = not empty, evt_code = head entry, and a pop occurs on evt_valid & evt_ready.
REQ-025 When full, a push with a simultaneous pop succeeds; a push without a pop drops the event and sets overflow.
REQ-026 A pop while empty has no effect.
REQ-027 Two or more keys changing in the same frame produce events in ascending index order.
REQ-028 Any bounce (frame mismatch) clears stable_cnt; deb is unchanged and no events are generated.
REQ-029 Latency from a clean press to evt_valid is at most (DEB_SCANS+1)*4*DWELL + 3 cycles.

Reset
REQ-030 While rst is high: out_s = 0000, evt_valid = 0, evt_code = 0, key_down = 0, overflow = 0; raw, deb, previous frame and stable_cnt are cleared; FIFO is empty; FSM = SCAN, col = 0, dwell = 0.
REQ-031 The first cycle after rst deasserts drives out_s = 1000.
REQ-032 Reset mid-EMIT or with a non-empty FIFO discards all pending events; overflow is cleared only by rst.

Configuration
REQ-033 With macro KEYPAD_RELEASE_EVT_EN defined, release keys are also emitted as {1'b1, key}; for the same key index the press entry precedes the release entry, and all entries are in ascending index.
REQ-034 Without KEYPAD_RELEASE_EVT_EN, releases update deb and key_down only, and evt_code[4] is constant 0.

Structure
REQ-035 Package keypad_pkg holds NUM_COLS = 4, NUM_ROWS = 4, NUM_KEYS = 16, KEY_W = 4, the event-code width, the FSM state enum, and the column one-hot encoding.
REQ-036 Sub-module keypad_evt_fifo implements the show-ahead synchronous FIFO (FIFO_DEPTH entries, 5-bit data, full/empty outputs).

Verification
REQ-037 Hold in_s = 0001 only during col 0 -> exactly one evt_code = 0x00, within 83 cycles at default parameters, and key_down = 1.
REQ-038 Key 6 (col 1, row 2) and key 9 (col 2, row 1) held together -> codes 0x06 then 0x09, on consecutive push cycles.
REQ-039 Key 5 toggling every 20 cycles for 200 cycles, then steady -> no events during toggling, then exactly one 0x05 event.
REQ-040 evt_ready = 0 while 6 distinct press events are generated -> 4 queued, overflow = 1; draining returns the 4 lowest keys in order.
REQ-041 Key 15 pressed then released with KEYPAD_RELEASE_EVT_EN -> 0x0F then 0x1F; without the macro -> 0x0F only, and key_down falls after release debounce.
REQ-042 rst asserted for 1 cycle during EMIT with 3 events queued -> evt_valid = 0, out_s = 0000 that cycle, and out_s = 1000 the next cycle.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared constants, FSM encoding and helpers for the 4x4 keypad scanner.
package keypad_pkg;
    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;
    localparam int NUM_KEYS = 16;
    localparam int KEY_W    = 4;
    localparam int CODE_W   = KEY_W + 1;

    typedef enum logic {
        ST_SCAN = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    // Column 0 drives the MSB of out_s.
    function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] col);
        col_drive = 4'b1000 >> col;
    endfunction

    function automatic logic [KEY_W-1:0] first_set(input logic [NUM_KEYS-1:0] v);
        first_set = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) first_set = KEY_W'(i);
        end
    endfunction
endpackage

// File: rtl/keypad_evt_fifo.sv
// Show-ahead synchronous event FIFO; head reads 0 while empty.
module keypad_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem_q[rd_q];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + 1'b1;
        end
        if (do_pop) rd_d = rd_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
        mem_q <= mem_d;
    end
endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad column scanner with frame debounce and an event queue.
// Define KEYPAD_RELEASE_EVT_EN to also queue release events.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int DWELL      = 4,
    parameter int DEB_SCANS  = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_ROWS-1:0] in_s,
    output logic [NUM_COLS-1:0] out_s,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CODE_W-1:0] evt_code,
    output logic              key_down,
    output logic              overflow
);
    state_e              state_q, state_d;
    logic [1:0]          col_q, col_d;
    logic [7:0]          dwell_q, dwell_d;
    logic [3:0]          stable_q, stable_d;
    logic [NUM_KEYS-1:0] raw_q, raw_d, prev_q, prev_d, deb_q, deb_d;
    logic [NUM_KEYS-1:0] press_q, press_d, pend_q, pend_d;
`ifdef KEYPAD_RELEASE_EVT_EN
    logic [NUM_KEYS-1:0] rel_q, rel_d;
`endif
    logic                key_down_q, key_down_d, ovf_q, ovf_d;
    logic                deb_load, push, pop, fifo_full, fifo_empty;
    logic [KEY_W-1:0]    emit_key;
    logic [CODE_W-1:0]   push_code, fifo_head;

`ifdef KEYPAD_RELEASE_EVT_EN
    assign pend_q = press_q | rel_q;
    assign pend_d = press_d | rel_d;
`else
    assign pend_q = press_q;
    assign pend_d = press_d;
`endif
    assign emit_key = first_set(pend_q);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_SCAN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SCAN: if (deb_load) state_d = ST_EMIT;
            ST_EMIT: if (pend_d == '0) state_d = ST_SCAN;
            default: state_d = ST_SCAN;
        endcase
    end

    always_comb begin
        col_d    = col_q;
        dwell_d  = dwell_q;
        raw_d    = raw_q;
        prev_d   = prev_q;
        stable_d = stable_q;
        deb_d    = deb_q;
        press_d  = press_q;
`ifdef KEYPAD_RELEASE_EVT_EN
        rel_d    = rel_q;
`endif
        deb_load  = 1'b0;
        push      = 1'b0;
        push_code = '0;
        if (state_q == ST_SCAN) begin
            if (dwell_q == 8'(DWELL - 1)) begin
                dwell_d = '0;
                col_d   = col_q + 1'b1;
                raw_d[{col_q, 2'b00} +: NUM_ROWS] = in_s;
                if (col_q == 2'(NUM_COLS - 1)) begin
                    prev_d = raw_d;
                    if (raw_d == prev_q) stable_d = (stable_q == 4'hf) ? stable_q : stable_q + 1'b1;
                    else                 stable_d = '0;
                    // Accept the frame once it has repeated enough and differs from the debounced state.
                    if (stable_d >= 4'(DEB_SCANS - 1) && raw_d != deb_q) begin
                        deb_load = 1'b1;
                        press_d  = raw_d & ~deb_q;
`ifdef KEYPAD_RELEASE_EVT_EN
                        rel_d    = deb_q & ~raw_d;
`endif
                        deb_d    = raw_d;
                    end
                end
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
        end else if (pend_q != '0) begin
            push = 1'b1;
`ifdef KEYPAD_RELEASE_EVT_EN
            if (press_q[emit_key]) begin
                push_code         = {1'b0, emit_key};
                press_d[emit_key] = 1'b0;
            end else begin
                push_code         = {1'b1, emit_key};
                rel_d[emit_key]   = 1'b0;
            end
`else
            push_code         = {1'b0, emit_key};
            press_d[emit_key] = 1'b0;
`endif
        end
    end

    assign key_down_d = |deb_d;
    assign ovf_d      = ovf_q | (push & fifo_full & ~pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q      <= '0;
            dwell_q    <= '0;
            raw_q      <= '0;
            prev_q     <= '0;
            stable_q   <= '0;
            deb_q      <= '0;
            press_q    <= '0;
`ifdef KEYPAD_RELEASE_EVT_EN
            rel_q      <= '0;
`endif
            key_down_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            col_q      <= col_d;
            dwell_q    <= dwell_d;
            raw_q      <= raw_d;
            prev_q     <= prev_d;
            stable_q   <= stable_d;
            deb_q      <= deb_d;
            press_q    <= press_d;
`ifdef KEYPAD_RELEASE_EVT_EN
            rel_q      <= rel_d;
`endif
            key_down_q <= key_down_d;
            ovf_q      <= ovf_d;
        end
    end

    // Outputs are forced quiet for the whole time rst is held.
    always_comb begin
        out_s     = (rst || state_q == ST_EMIT) ? '0 : col_drive(col_q);
        evt_valid = ~rst & ~fifo_empty;
        evt_code  = rst ? '0 : fifo_head;
        key_down  = ~rst & key_down_q;
        overflow  = ~rst & ovf_q;
        pop       = evt_valid & evt_ready;
    end

    keypad_evt_fifo #(.DEPTH(FIFO_DEPTH), .DW(CODE_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_code),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed self-checking bench for keypad_scan_ctrl at default parameters.
module tb_keypad_scan_ctrl;
    logic        clk;
    logic        rst;
    logic [3:0]  in_s;
    logic [3:0]  out_s;
    logic        evt_valid;
    logic        evt_ready;
    logic [4:0]  evt_code;
    logic        key_down;
    logic        overflow;
    logic [15:0] keys;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [4:0] log_code[$];
    int         log_cyc[$];

    keypad_scan_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_s      (in_s),
        .out_s     (out_s),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .key_down  (key_down),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: the driven column returns its four pressed rows.
    always_comb begin
        in_s = '0;
        for (int c = 0; c < 4; c++) begin
            if (out_s[3-c]) in_s = keys[c*4 +: 4];
        end
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            log_code.push_back(evt_code);
            log_cyc.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lg(input int i);
        return (i < log_code.size()) ? 32'(log_code[i]) : 32'hBAD;
    endfunction

    task automatic reset_dut();
        rst = 1'b1;
        keys = '0;
        tick(2);
        rst = 1'b0;
        log_code.delete();
        log_cyc.delete();
    endtask

    initial begin
        bit got;
        rst = 1'b1;
        keys = '0;
        evt_ready = 1'b1;
        tick(3);
        chk("rst_out_s", 32'(out_s), 32'h0);
        chk("rst_evt_valid", 32'(evt_valid), 32'h0);
        chk("rst_evt_code", 32'(evt_code), 32'h0);
        chk("rst_key_down", 32'(key_down), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        rst = 1'b0;
        #1;
        chk("first_col", 32'(out_s), 32'h8);
        tick(4);
        chk("second_col", 32'(out_s), 32'h4);
        tick(12);
        chk("col_wrap", 32'(out_s), 32'h8);

        // single key 0
        reset_dut();
        keys = 16'h0001;
        got = 1'b0;
        for (int i = 0; i < 83 && !got; i++) begin
            tick(1);
            if (evt_valid) got = 1'b1;
        end
        chk("k0_latency", 32'(got), 32'h1);
        chk("k0_code", 32'(evt_code), 32'h00);
        chk("k0_key_down", 32'(key_down), 32'h1);
        tick(100);
        chk("k0_count", 32'(log_code.size()), 32'd1);
        chk("k0_logged", lg(0), 32'h00);

        // keys 6 and 9 together
        reset_dut();
        keys = 16'h0240;
        tick(120);
        chk("k69_count", 32'(log_code.size()), 32'd2);
        chk("k69_first", lg(0), 32'h06);
        chk("k69_second", lg(1), 32'h09);
        chk("k69_consec", (log_cyc.size() == 2) ? 32'(log_cyc[1] - log_cyc[0]) : 32'hBAD, 32'd1);

        // bouncing key 5
        reset_dut();
        for (int i = 0; i < 10; i++) begin
            keys = (i % 2 == 0) ? 16'h0020 : 16'h0000;
            tick(20);
        end
        chk("bounce_none", 32'(log_code.size()), 32'd0);
        chk("bounce_key_down", 32'(key_down), 32'h0);
        keys = 16'h0020;
        tick(120);
        chk("bounce_count", 32'(log_code.size()), 32'd1);
        chk("bounce_code", lg(0), 32'h05);

        // six presses against a stalled consumer
        reset_dut();
        evt_ready = 1'b0;
        keys = 16'h49A4;
        tick(80);
        chk("ovf_valid", 32'(evt_valid), 32'h1);
        chk("ovf_flag", 32'(overflow), 32'h1);
        chk("ovf_head", 32'(evt_code), 32'h02);
        evt_ready = 1'b1;
        tick(10);
        chk("ovf_drain_cnt", 32'(log_code.size()), 32'd4);
        chk("ovf_drain0", lg(0), 32'h02);
        chk("ovf_drain1", lg(1), 32'h05);
        chk("ovf_drain2", lg(2), 32'h07);
        chk("ovf_drain3", lg(3), 32'h08);
        chk("ovf_empty", 32'(evt_valid), 32'h0);
        chk("ovf_sticky", 32'(overflow), 32'h1);

        // key 15 press and release
        reset_dut();
        keys = 16'h8000;
        tick(80);
        chk("k15_down", 32'(key_down), 32'h1);
        keys = 16'h0000;
        tick(16);
        chk("k15_hold", 32'(key_down), 32'h1);
        tick(64);
        chk("k15_up", 32'(key_down), 32'h0);
        chk("k15_first", lg(0), 32'h0F);
`ifdef KEYPAD_RELEASE_EVT_EN
        chk("k15_count", 32'(log_code.size()), 32'd2);
        chk("k15_release", lg(1), 32'h1F);
`else
        chk("k15_count", 32'(log_code.size()), 32'd1);
`endif

        // reset in the middle of emission
        reset_dut();
        evt_ready = 1'b0;
        keys = 16'h000F;
        got = 1'b0;
        for (int i = 0; i < 80 && !got; i++) begin
            tick(1);
            if (out_s == 4'b0000) got = 1'b1;
        end
        chk("emit_seen", 32'(got), 32'h1);
        tick(3);
        chk("emit_queued", 32'(evt_valid), 32'h1);
        chk("emit_out_s", 32'(out_s), 32'h0);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(evt_valid), 32'h0);
        chk("mid_rst_out_s", 32'(out_s), 32'h0);
        tick(1);
        rst = 1'b0;
        #1;
        chk("post_rst_out_s", 32'(out_s), 32'h8);
        chk("post_rst_valid", 32'(evt_valid), 32'h0);
        tick(2);
        chk("post_rst_flushed", 32'(evt_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
